// File: rtl/sort_feeder_if.sv
// sort_feeder_if: groups the Avalon-ST style sink and the sorter-side
// control/data signals of sort_feeder.
//
// Handshake: a word moves on a cycle where snk_valid_i and snk_ready_o are
// both high at the rising clock edge. The source holds data, SOP and EOP
// stable while valid is high. Ready does not depend on valid in the same
// cycle, because it is a registered output.
//
// state_dbg_o is a debug view of the feeder FSM state.
interface sort_feeder_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
);
    logic [DWIDTH-1:0] snk_data_i;
    logic              snk_startofpacket_i;
    logic              snk_endofpacket_i;
    logic              snk_valid_i;
    logic              snk_ready_o;
    logic              sort_done_i;
    logic              wren_o;
    logic              sort_op_o;
    logic              clear_op_o;
    logic [AWIDTH-1:0] cntr_o;
    logic [DWIDTH-1:0] data_o;
    logic              busy_o;
    logic [2:0]        state_dbg_o;

    // Feeder side.
    modport slave (
        input  snk_data_i, snk_startofpacket_i, snk_endofpacket_i,
               snk_valid_i, sort_done_i,
        output snk_ready_o, wren_o, sort_op_o, clear_op_o, cntr_o, data_o,
               busy_o, state_dbg_o
    );

    // Packet source / sorter model side.
    modport master (
        output snk_data_i, snk_startofpacket_i, snk_endofpacket_i,
               snk_valid_i, sort_done_i,
        input  snk_ready_o, wren_o, sort_op_o, clear_op_o, cntr_o, data_o,
               busy_o, state_dbg_o
    );
endinterface

// File: rtl/sort_feeder.sv
// sort_feeder: buffers one packet of up to 2**AWIDTH words, replays it into
// the sorter write port, waits for sort and drain, then clears the sorter.
// Optional macro SORT_FEEDER_OVERSIZE_DROP_EN: oversize packets are dropped
// at EOP and a sticky oversize_o flag is raised. Without it, oversize packets
// are truncated to their first 2**AWIDTH words.
module sort_feeder #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic           clk_i,
    input  logic           srst_i,
    sort_feeder_if.slave   bus
`ifdef SORT_FEEDER_OVERSIZE_DROP_EN
    ,
    output logic           oversize_o
`endif
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] MAX_LEN = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] ONE     = {{AWIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RECV      = 3'd1,
        FEED      = 3'd2,
        WAIT_SORT = 3'd3,
        DRAIN     = 3'd4,
        CLEAR     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] mem_d [DEPTH];
    logic [AWIDTH:0]   len_q, len_d;
    logic [AWIDTH:0]   idx_q, idx_d;     // feed index, then drain cycle count
    logic              ovf_q, ovf_d;     // current packet overflowed
    logic              sticky_q, sticky_d;
    logic              ready_q, ready_d;
    logic              sort_op_q, sort_op_d;
    logic              clear_q, clear_d;
    logic [AWIDTH-1:0] cntr_q, cntr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              busy_q, busy_d;

    logic              xfer;
    logic              start_feed;
    logic [DWIDTH-1:0] first_word;
    logic [AWIDTH:0]   final_len;

    assign xfer = bus.snk_valid_i & ready_q;

    // Next-state and next-output computation for the whole feeder.
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        len_d      = len_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        sticky_d   = sticky_q;
        ready_d    = ready_q;
        sort_op_d  = sort_op_q;
        clear_d    = clear_q;
        cntr_d     = cntr_q;
        data_d     = data_q;
        start_feed = 1'b0;
        first_word = mem_q[0];
        final_len  = len_q;

        case (state_q)
            IDLE, RECV: begin
                if (xfer && bus.snk_startofpacket_i) begin
                    // SOP always (re)starts the packet at buf[0].
                    mem_d[0]   = bus.snk_data_i;
                    len_d      = ONE;
                    ovf_d      = 1'b0;
                    first_word = bus.snk_data_i;
                    final_len  = ONE;
                    if (bus.snk_endofpacket_i) start_feed = 1'b1;
                    else                       state_d    = RECV;
                end else if (xfer && state_q == RECV) begin
                    if (len_q == MAX_LEN) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_d[len_q[AWIDTH-1:0]] = bus.snk_data_i;
                        len_d = len_q + ONE;
                    end
                    first_word = mem_q[0];
                    final_len  = len_d;
                    if (bus.snk_endofpacket_i) begin
`ifdef SORT_FEEDER_OVERSIZE_DROP_EN
                        if (ovf_d) begin
                            state_d  = IDLE;
                            sticky_d = 1'b1;
                        end else begin
                            start_feed = 1'b1;
                        end
`else
                        start_feed = 1'b1;
`endif
                    end
                end
            end
            FEED: begin
                if (idx_q == len_q) begin
                    sort_op_d = 1'b0;
                    state_d   = WAIT_SORT;
                end else begin
                    data_d = mem_q[idx_q[AWIDTH-1:0]];
                    idx_d  = idx_q + ONE;
                end
            end
            WAIT_SORT: begin
                if (bus.sort_done_i) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end
            end
            DRAIN: begin
                // The sorter emits len words plus one done cycle.
                if (idx_q == len_q) begin
                    state_d = CLEAR;
                    clear_d = 1'b1;
                end else begin
                    idx_d = idx_q + ONE;
                end
            end
            CLEAR: begin
                state_d = IDLE;
                clear_d = 1'b0;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (start_feed) begin
            state_d   = FEED;
            ready_d   = 1'b0;
            sort_op_d = 1'b1;
            data_d    = first_word;
            cntr_d    = final_len[AWIDTH-1:0];
            len_d     = final_len;
            idx_d     = ONE;
        end

        busy_d = (state_d != IDLE);
    end

    // State, buffer and registered outputs; synchronous reset.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            mem_q     <= '{default: '0};
            len_q     <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            sticky_q  <= 1'b0;
            ready_q   <= 1'b1;
            sort_op_q <= 1'b0;
            clear_q   <= 1'b0;
            cntr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            sticky_q  <= sticky_d;
            ready_q   <= ready_d;
            sort_op_q <= sort_op_d;
            clear_q   <= clear_d;
            cntr_q    <= cntr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.snk_ready_o = ready_q;
    assign bus.sort_op_o   = sort_op_q;
    assign bus.wren_o      = sort_op_q;
    assign bus.clear_op_o  = clear_q;
    assign bus.cntr_o      = cntr_q;
    assign bus.data_o      = data_q;
    assign bus.busy_o      = busy_q;
    assign bus.state_dbg_o = state_q;

`ifdef SORT_FEEDER_OVERSIZE_DROP_EN
    assign oversize_o = sticky_q;
`else
    logic unused_sticky;
    assign unused_sticky = sticky_q;
`endif

endmodule
